// File: rtl/iso_tu_scheduler.sv
// iso_tu_scheduler: isochronous TU scheduler producing per-lane data/stuffing/blank/idle selects
// Ports: clk, rst_n (async active-low); sched_start/sched_stop control; cfg_* timing config
// latched on start; sched_state, per-lane sched_sel/stream_en/blank_en/idle_en, sched_bs,
// sched_blank_id, sched_sr, sched_busy outputs, all registered.
// Optional macro ISO_SCHED_SR_EN: every 512th blank start emits sched_sr instead of sched_bs.
module iso_tu_scheduler #(
  parameter int MAX_LANES = 4,
  parameter int TU_SIZE   = 64,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sched_start,
  input  logic                           sched_stop,
  input  logic [$clog2(MAX_LANES):0]     cfg_lanes,
  input  logic [5:0]                     cfg_tu_vld_size,
  input  logic [3:0]                     cfg_alt_up,
  input  logic [3:0]                     cfg_alt_down,
  input  logic [CNT_W-1:0]               cfg_h_active_sym,
  input  logic [CNT_W-1:0]               cfg_h_blank_sym,
  input  logic [CNT_W-1:0]               cfg_v_active,
  input  logic [CNT_W-1:0]               cfg_v_blank,
  output logic [1:0]                     sched_state,
  output logic [MAX_LANES-1:0]           sched_stream_en,
  output logic [MAX_LANES-1:0]           sched_blank_en,
  output logic [MAX_LANES-1:0]           sched_idle_en,
  output logic [2*MAX_LANES-1:0]         sched_sel,
  output logic                           sched_bs,
  output logic                           sched_blank_id,
  output logic                           sched_sr,
  output logic                           sched_busy
);
  localparam int LW  = $clog2(MAX_LANES) + 1;
  localparam int TPW = $clog2(TU_SIZE);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACTIVE = 2'b01, S_HBLANK = 2'b10, S_VBLANK = 2'b11} state_t;
  state_t                 r_state;
  logic [CNT_W:0]         r_hcnt;
  logic [CNT_W:0]         r_line;
  logic [TPW-1:0]         r_tu_pos;
  logic [4:0]             r_tu_idx;
  logic [5:0]             r_vld;
  logic [3:0]             r_alt_up;
  logic [3:0]             r_alt_dn;
  logic [CNT_W-1:0]       r_h_act;
  logic [CNT_W-1:0]       r_h_blk;
  logic [CNT_W-1:0]       r_v_act;
  logic [CNT_W-1:0]       r_v_blk;
  logic [MAX_LANES-1:0]   r_mask;
  logic [1:0]             r_o_state;
  logic [2*MAX_LANES-1:0] r_sel;
  logic [MAX_LANES-1:0]   r_stream;
  logic [MAX_LANES-1:0]   r_blank;
  logic [MAX_LANES-1:0]   r_idle;
  logic                   r_bs;
  logic                   r_bid;
  logic                   r_busy;
  logic [LW-1:0]          w_lanes;
  logic [MAX_LANES-1:0]   w_mask;
  logic [4:0]             w_alt_sum;
  logic                   w_up;
  logic [6:0]             w_vld_raw;
  logic [6:0]             w_cur_vld;
  logic [1:0]             w_kind;
  logic [2*MAX_LANES-1:0] w_sel;
  logic                   w_bs_evt;
  logic                   w_sr_hit;
  logic [CNT_W:0]         w_hcnt_nx;
  logic [CNT_W:0]         w_line_nx;
  logic [CNT_W:0]         w_h_tot;
  logic [CNT_W:0]         w_v_tot;
  logic                   w_tu_wrap;
  logic [4:0]             w_tu_idx_inc;
  logic [4:0]             w_tu_idx_nx;
  state_t                 w_first;
  state_t                 w_start_st;
  // lane count: 0 behaves as 1, oversize clamps to the physical lane count
  assign w_lanes = (cfg_lanes == '0) ? LW'(1) : (cfg_lanes > LW'(MAX_LANES)) ? LW'(MAX_LANES) : cfg_lanes;
  // valid size for the current TU: +1 during the first alt_up TUs of each alternation period
  assign w_alt_sum    = {1'b0, r_alt_up} + {1'b0, r_alt_dn};
  assign w_up         = (w_alt_sum != 5'd0) && (r_tu_idx < {1'b0, r_alt_up});
  assign w_vld_raw    = {1'b0, r_vld} + {6'd0, w_up};
  assign w_cur_vld    = (w_vld_raw > 7'(TU_SIZE)) ? 7'(TU_SIZE) : w_vld_raw;
  assign w_kind       = (r_state == S_IDLE) ? 2'b00 :
                        (r_state == S_ACTIVE) ? ((7'(r_tu_pos) < w_cur_vld) ? 2'b01 : 2'b10) : 2'b11;
  assign w_bs_evt     = r_state[1] && (r_hcnt == '0);
  assign w_hcnt_nx    = r_hcnt + 1'b1;
  assign w_line_nx    = r_line + 1'b1;
  assign w_h_tot      = {1'b0, r_h_act} + {1'b0, r_h_blk};
  assign w_v_tot      = {1'b0, r_v_act} + {1'b0, r_v_blk};
  assign w_tu_wrap    = r_tu_pos == TPW'(TU_SIZE - 1);
  assign w_tu_idx_inc = r_tu_idx + 5'd1;
  assign w_tu_idx_nx  = (w_tu_idx_inc >= w_alt_sum) ? 5'd0 : w_tu_idx_inc;
  // a line with no active symbols starts directly in HBLANK
  assign w_first      = (r_h_act == '0) ? S_HBLANK : S_ACTIVE;
  assign w_start_st   = (cfg_h_active_sym == '0) ? S_HBLANK : S_ACTIVE;
  for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
    assign w_mask[g]         = LW'(g) < w_lanes;
    assign w_sel[2*g +: 2]   = r_mask[g] ? w_kind : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hcnt    <= '0;
      r_line    <= '0;
      r_tu_pos  <= '0;
      r_tu_idx  <= '0;
      r_vld     <= '0;
      r_alt_up  <= '0;
      r_alt_dn  <= '0;
      r_h_act   <= '0;
      r_h_blk   <= '0;
      r_v_act   <= '0;
      r_v_blk   <= '0;
      r_mask    <= '0;
      r_o_state <= '0;
      r_sel     <= '0;
      r_stream  <= '0;
      r_blank   <= '0;
      r_idle    <= '0;
      r_bs      <= 1'b0;
      r_bid     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_o_state <= r_state;
      r_sel     <= w_sel;
      r_stream  <= r_mask & {MAX_LANES{w_kind == 2'b01}};
      r_blank   <= r_mask & {MAX_LANES{w_kind == 2'b11}};
      r_idle    <= r_mask & {MAX_LANES{w_kind == 2'b00}};
      r_bs      <= w_bs_evt && !w_sr_hit;
      r_bid     <= r_state == S_VBLANK;
      r_busy    <= r_state != S_IDLE;
      if (sched_stop) begin
        r_state  <= S_IDLE;
        r_hcnt   <= '0;
        r_line   <= '0;
        r_tu_pos <= '0;
        r_tu_idx <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (sched_start) begin
            r_vld    <= cfg_tu_vld_size;
            r_alt_up <= cfg_alt_up;
            r_alt_dn <= cfg_alt_down;
            r_h_act  <= cfg_h_active_sym;
            r_h_blk  <= cfg_h_blank_sym;
            r_v_act  <= cfg_v_active;
            r_v_blk  <= cfg_v_blank;
            r_mask   <= w_mask;
            r_state  <= w_start_st;
          end
          S_ACTIVE: if (w_hcnt_nx >= {1'b0, r_h_act}) begin
            r_state  <= S_HBLANK;
            r_hcnt   <= '0;
            r_tu_pos <= '0;
            r_tu_idx <= '0;
          end else begin
            r_hcnt   <= w_hcnt_nx;
            r_tu_pos <= w_tu_wrap ? '0 : r_tu_pos + 1'b1;
            r_tu_idx <= w_tu_wrap ? w_tu_idx_nx : r_tu_idx;
          end
          S_HBLANK: if (w_hcnt_nx >= {1'b0, r_h_blk}) begin
            r_hcnt  <= '0;
            r_line  <= (w_line_nx < {1'b0, r_v_act} || r_v_blk != '0) ? w_line_nx : '0;
            r_state <= (w_line_nx < {1'b0, r_v_act} || r_v_blk == '0) ? w_first : S_VBLANK;
          end else begin
            r_hcnt <= w_hcnt_nx;
          end
          S_VBLANK: if (w_hcnt_nx >= w_h_tot) begin
            r_hcnt  <= '0;
            r_line  <= (w_line_nx >= w_v_tot) ? '0 : w_line_nx;
            r_state <= (w_line_nx >= w_v_tot) ? w_first : S_VBLANK;
          end else begin
            r_hcnt <= w_hcnt_nx;
          end
        endcase
      end
    end
  end
`ifdef ISO_SCHED_SR_EN
  logic [8:0] r_bs_cnt;
  logic       r_sr;
  // the 512th blank start since start/stop replaces its bs pulse with sr
  assign w_sr_hit = w_bs_evt && (&r_bs_cnt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bs_cnt <= '0;
      r_sr     <= 1'b0;
    end else begin
      r_sr     <= w_sr_hit;
      r_bs_cnt <= (sched_stop || (sched_start && r_state == S_IDLE)) ? 9'd0 : w_bs_evt ? r_bs_cnt + 9'd1 : r_bs_cnt;
    end
  end
  assign sched_sr = r_sr;
`else
  assign w_sr_hit = 1'b0;
  assign sched_sr = 1'b0;
`endif
  assign sched_state     = r_o_state;
  assign sched_sel       = r_sel;
  assign sched_stream_en = r_stream;
  assign sched_blank_en  = r_blank;
  assign sched_idle_en   = r_idle;
  assign sched_bs        = r_bs;
  assign sched_blank_id  = r_bid;
  assign sched_busy      = r_busy;
endmodule

// File: tb/tb_iso_tu_scheduler.sv
// tb_iso_tu_scheduler: checks iso_tu_scheduler against a frame-arithmetic reference model
module tb_iso_tu_scheduler;
  localparam int N  = 4;
  localparam int TU = 64;
  localparam int CW = 16;
  localparam int LW = 3;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [LW-1:0] c_lanes = '0;
  logic [5:0]    c_vld = '0;
  logic [3:0]    c_up = '0;
  logic [3:0]    c_dn = '0;
  logic [CW-1:0] c_ha = '0;
  logic [CW-1:0] c_hb = '0;
  logic [CW-1:0] c_va = '0;
  logic [CW-1:0] c_vb = '0;
  logic [1:0]    o_state;
  logic [N-1:0]  o_stream;
  logic [N-1:0]  o_blank;
  logic [N-1:0]  o_idle;
  logic [2*N-1:0] o_sel;
  logic          o_bs;
  logic          o_bid;
  logic          o_sr;
  logic          o_busy;
  logic [63:0]   w_obs;
  int n_chk = 0;
  int n_fail = 0;
  int m_lanes, m_vld, m_up, m_dn, m_ha, m_hb, m_va, m_vb;
  int m_mask_n = 0;
  int bs_k = 0;
  logic [63:0] e;
  iso_tu_scheduler #(.MAX_LANES(N), .TU_SIZE(TU), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sched_start(start), .sched_stop(stop),
    .cfg_lanes(c_lanes), .cfg_tu_vld_size(c_vld), .cfg_alt_up(c_up), .cfg_alt_down(c_dn),
    .cfg_h_active_sym(c_ha), .cfg_h_blank_sym(c_hb), .cfg_v_active(c_va), .cfg_v_blank(c_vb),
    .sched_state(o_state), .sched_stream_en(o_stream), .sched_blank_en(o_blank),
    .sched_idle_en(o_idle), .sched_sel(o_sel), .sched_bs(o_bs), .sched_blank_id(o_bid),
    .sched_sr(o_sr), .sched_busy(o_busy)
  );
  always #5 clk = ~clk;
  assign w_obs = 64'({o_state, o_sel, o_stream, o_blank, o_idle, o_bs, o_sr, o_bid, o_busy});
  function automatic int clampl(input int l);
    return (l == 0) ? 1 : (l > N) ? N : l;
  endfunction
  // kind: 0 idle, 1 data, 2 stuffing, 3 blank
  function automatic logic [63:0] pack(input int st, input int kind, input int nl, input bit bs, input bit sr);
    logic [2*N-1:0] sl;
    logic [N-1:0] se, be, ie;
    logic [1:0] s;
    sl = '0; se = '0; be = '0; ie = '0;
    s = 2'(st);
    for (int i = 0; i < N; i++) begin
      if (i < nl) begin
        sl[2*i +: 2] = 2'(kind);
        se[i] = kind == 1;
        be[i] = kind == 3;
        ie[i] = kind == 0;
      end
    end
    return 64'({s, sl, se, be, ie, bs, sr, s == 2'b11, s != 2'b00});
  endfunction
  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    n_chk++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask
  // expected outputs t cycles after the first ACTIVE/HBLANK cycle of a run
  task automatic exp_at(input int t, output logic [63:0] v);
    int l_len, f_len, r, line, pos, st, kind, sum, idx, vv;
    bit bs, sr;
    l_len = m_ha + m_hb;
    f_len = (m_va + m_vb) * l_len;
    r = t % f_len;
    line = r / l_len;
    pos = r % l_len;
    bs = 0;
    if (line < m_va && pos < m_ha) begin
      st = 1;
      sum = m_up + m_dn;
      idx = (sum != 0) ? (pos / TU) % sum : 0;
      vv = m_vld + ((sum != 0 && idx < m_up) ? 1 : 0);
      if (vv > TU) vv = TU;
      kind = (pos % TU < vv) ? 1 : 2;
    end else begin
      st = (line < m_va) ? 2 : 3;
      kind = 3;
      bs = pos == ((line < m_va) ? m_ha : 0);
    end
`ifdef ISO_SCHED_SR_EN
    sr = bs && (bs_k % 512 == 511);
`else
    sr = 0;
`endif
    if (bs) bs_k++;
    v = pack(st, kind, clampl(m_lanes), bs && !sr, sr);
  endtask
  task automatic setcfg(input int l, input int vld, input int up, input int dn, input int ha, input int hb, input int va, input int vb);
    m_lanes = l; m_vld = vld; m_up = up; m_dn = dn; m_ha = ha; m_hb = hb; m_va = va; m_vb = vb;
  endtask
  task automatic run(input int n, input bit scr);
    int old_n;
    c_lanes = LW'(m_lanes); c_vld = 6'(m_vld); c_up = 4'(m_up); c_dn = 4'(m_dn);
    c_ha = CW'(m_ha); c_hb = CW'(m_hb); c_va = CW'(m_va); c_vb = CW'(m_vb);
    old_n = m_mask_n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_lat", w_obs, pack(0, 0, old_n, 0, 0));
    m_mask_n = clampl(m_lanes);
    bs_k = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      exp_at(t, e);
      check("run", w_obs, e);
      if (scr) begin
        c_lanes = LW'($urandom); c_vld = 6'($urandom); c_up = 4'($urandom); c_dn = 4'($urandom);
        c_ha = CW'($urandom); c_hb = CW'($urandom); c_va = CW'($urandom); c_vb = CW'($urandom);
      end
    end
  endtask
  task automatic do_stop(input int t_next);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    exp_at(t_next, e);
    check("stop_lag", w_obs, e);
    @(negedge clk);
    check("stop_idle", w_obs, pack(0, 0, m_mask_n, 0, 0));
  endtask
  initial begin
    #2;
    check("reset", w_obs, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", w_obs, 64'd0);
    setcfg(4, 40, 0, 0, 128, 16, 2, 1);
    run(900, 1'b1);
    do_stop(900);
    setcfg(4, 10, 1, 2, 256, 8, 1, 0);
    run(600, 1'b0);
    do_stop(600);
    setcfg(2, 40, 0, 0, 128, 16, 2, 1);
    run(300, 1'b0);
    do_stop(300);
    setcfg(4, 40, 0, 0, 100, 5, 2, 0);
    run(250, 1'b0);
    do_stop(250);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_a", w_obs, pack(0, 0, m_mask_n, 0, 0));
    @(negedge clk);
    check("start_stop_b", w_obs, pack(0, 0, m_mask_n, 0, 0));
    setcfg(7, 63, 3, 1, 70, 3, 1, 1);
    run(200, 1'b0);
    do_stop(200);
    setcfg(0, 5, 0, 0, 0, 1, 1, 0);
    run(1030, 1'b0);
    do_stop(1030);
    setcfg(3, 20, 2, 2, 90, 4, 2, 2);
    run(50, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst", w_obs, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_mask_n = 0;
    @(negedge clk);
    check("post_rst", w_obs, 64'd0);
    run(150, 1'b0);
    do_stop(150);
    for (int k = 0; k < 8; k++) begin
      setcfg($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 200), $urandom_range(1, 20), $urandom_range(1, 3), $urandom_range(0, 2));
      run(500, 1'b1);
      do_stop(500);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iso_tu_scheduler.md
# iso_tu_scheduler

Parametrised isochronous transfer-unit (TU) scheduler for the DisplayPort main-link path, generalising the fixed four-lane scheduler to `MAX_LANES` lanes. It adds fractional TU valid-size alternation and frame-level vertical-blank sequencing. From a latched timing configuration it generates per-lane stream, stuffing, blank and idle selects cycle by cycle, and feeds the lane steering/mux stage.

## Interface
- `MAX_LANES`, 4: physical lanes, power of two, 1..8.
- `TU_SIZE`, 64: symbols per TU, 32..64.
- `CNT_W`, 16: width of symbol and line counters.
- `clk` in 1: link symbol clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sched_start` in 1: pulse; latches all `cfg_*` and starts frame 0, line 0. Ignored while not IDLE.
- `sched_stop` in 1: level/pulse; forces IDLE next cycle. Wins over `sched_start`.
- `cfg_lanes` in $clog2(MAX_LANES)+1: active lanes, 1..MAX_LANES. 0 is treated as 1; values above MAX_LANES are clamped.
- `cfg_tu_vld_size` in 6: base valid symbols per TU.
- `cfg_alt_up` in 4, `cfg_alt_down` in 4: fractional pattern.
- `cfg_h_active_sym` in CNT_W: active-symbol cycles per line.
- `cfg_h_blank_sym` in CNT_W: blank cycles per line, ≥1.
- `cfg_v_active` in CNT_W: active lines, ≥1.
- `cfg_v_blank` in CNT_W: vertical-blank lines.
- `sched_state` out 2: 00 IDLE, 01 ACTIVE, 10 HBLANK, 11 VBLANK.
- `sched_stream_en` out MAX_LANES: lane carries pixel data.
- `sched_blank_en` out MAX_LANES: lane in blanking.
- `sched_idle_en` out MAX_LANES: lane idle.
- `sched_sel` out 2*MAX_LANES: lane i uses bits [2i+1:2i]. 00 idle, 01 data, 10 stuffing, 11 blank.
- `sched_bs` out 1: pulse on the first cycle of each blank period.
- `sched_blank_id` out 1: 1 while in VBLANK.
- `sched_sr` out 1: scrambler-reset marker (see Configuration).
- `sched_busy` out 1: state ≠ IDLE.

## Operation
- **IDLE:** every active lane has `sel`=00 and `idle_en`=1.
- **Active line:** ACTIVE for `cfg_h_active_sym` cycles, then HBLANK for `cfg_h_blank_sym` cycles.
  - Line counter advances at the end of HBLANK.
  - After `cfg_v_active` lines, enter VBLANK for `cfg_v_blank` lines. Each VBLANK line lasts h_active+h_blank cycles.
  - Then wrap to line 0 of the next frame. Runs until stop.
  - If `cfg_v_blank`=0, VBLANK is skipped.
- **ACTIVE TU structure:**
  - Symbol counter `tu_pos` runs 0..TU_SIZE-1 and wraps.
  - Cycles with `tu_pos` < `cur_vld` are data (`sel`=01, `stream_en`=1). The rest of the TU is stuffing (`sel`=10, `stream_en`=0, `idle_en`=0).
  - `cur_vld` = `cfg_tu_vld_size`+1 when `tu_idx` < `cfg_alt_up`, else `cfg_tu_vld_size`.
  - `tu_idx` counts TUs modulo (`cfg_alt_up`+`cfg_alt_down`). If the sum is 0, `cur_vld` = `cfg_tu_vld_size`.
  - `cur_vld` is clamped to TU_SIZE.
  - `tu_pos` and `tu_idx` reset to 0 at the start of every line, so a partial last TU is truncated.
- **HBLANK/VBLANK:** every active lane has `sel`=11 and `blank_en`=1. `sched_bs`=1 on the first blank cycle of every line, including VBLANK lines.
- **Inactive lanes:** lanes ≥ `cfg_lanes` always have `sel`=00 and all enables 0.
- **Empty active portion:** if `cfg_h_active_sym`=0, ACTIVE is skipped and the line is pure HBLANK.
- **Config changes:** changes to `cfg_*` after start have no effect until the next start.

## Timing
- All outputs are registered.
- **Reset values:** `sched_state`=00; `sched_sel`=0; `stream_en`=0; `blank_en`=0; `idle_en`={MAX_LANES{1}} masked to 0 (no lanes latched); `sched_bs`=0; `sched_blank_id`=0; `sched_sr`=0; `sched_busy`=0.
- **Start latency:** `sched_start` sampled high at edge N gives the first ACTIVE cycle (`sel`=01) visible after edge N+1.
- **Stop latency:** `sched_stop` at edge N gives IDLE outputs after edge N+1. Counters are cleared.
- **State transitions:** exactly at the cycle boundaries given above, with no bubble cycles between ACTIVE, HBLANK and VBLANK.
- **Mid-operation reset:** reset asserted mid-operation returns all outputs to reset values immediately (asynchronous assert). Release is synchronous to `clk`.

## Configuration
- Macro `ISO_SCHED_SR_EN`.
- **Defined:** a 9-bit BS counter counts `sched_bs` pulses. Every 512th blank start (counter=511, wrapping) asserts `sched_sr` instead of `sched_bs` for that cycle. The counter clears on start/stop.
- **Undefined:** `sched_sr` is tied to 0 and every blank start asserts `sched_bs`.

## Test plan
- **Basic line:** MAX_LANES=4, lanes=4, vld=40, alt 0/0, h_active=128, h_blank=16, v_active=2, v_blank=1 → per line: 40 data and 24 stuffing, twice; then 16 blank with `bs` on the first blank cycle. The third line is VBLANK (144 cycles, `blank_id`=1). Line 0 repeats after that.
- **Fractional alternation:** vld=10, alt_up=1, alt_down=2 → TU valid counts of 11, 10, 10, 11, 10, 10…
- **Lane masking:** lanes=2 → lanes 2–3 have `sel`=00 and enables 0 in every state. Lanes 0–1 are identical.
- **Truncated TU:** h_active=100, TU_SIZE=64, vld=40 → TU1 shows 36 cycles (all data), then HBLANK with no gap.
- **Stop and restart:** `stop` mid-TU → IDLE after 1 cycle. `start` + `stop` in the same cycle → stays IDLE. A new start resumes at line 0, `tu_pos` 0.
- **Scrambler reset with `ISO_SCHED_SR_EN`:** 512 lines → `sr`=1 at the 512th blank start and `bs`=0 there. Without the macro, `sr` is never 1.
